// File: rtl/fb_reader.sv
// ---------------------------------------------------------------------------
// fb_reader
//
// Wishbone classic read master that walks the frame buffer in raster order
// (byte address = 2*(HDISP*y + x)) and hands 16-bit pixels to the display
// pipeline through a small synchronous FIFO. Single clock domain.
//
// Optional feature macro: FB_READER_FAIRPLAY_EN
//   When defined, the master releases the bus for one cycle after every
//   64th completed transfer so other arbiter clients get a turn.
//
// Parameters
//   HDISP       active pixels per line
//   VDISP       active lines per frame
//   FIFO_DEPTH  FIFO entries (power of 2, >= 4)
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   wshb_adr              byte address of the current read
//   wshb_dat_ms           write data, always 0
//   wshb_dat_sm           read data from the slave
//   wshb_sel              byte selects, always 2'b11
//   wshb_we               always 0 (read only)
//   wshb_cti, wshb_bte    always 0 (classic cycles)
//   wshb_stb, wshb_cyc    strobe / cycle
//   wshb_ack              slave acknowledge
//   pix_data              FIFO head pixel
//   pix_sof               head pixel is (0,0)
//   pix_eol               head pixel is last of its line
//   pix_valid             FIFO not empty
//   pix_ready             consumer accepts the head pixel
// ---------------------------------------------------------------------------
module fb_reader #(
  parameter int HDISP      = 640,
  parameter int VDISP      = 480,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] wshb_adr,
  output logic [15:0] wshb_dat_ms,
  input  logic [15:0] wshb_dat_sm,
  output logic [1:0]  wshb_sel,
  output logic        wshb_we,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  output logic        wshb_stb,
  output logic        wshb_cyc,
  input  logic        wshb_ack,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  // Highest occupancy at which another read may still be started.
  localparam logic [CW-1:0] FILL_LIMIT = CW'(FIFO_DEPTH - 2);

`ifdef FB_READER_FAIRPLAY_EN
  typedef enum logic [1:0] {IDLE, READ, PAUSE} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ} state_t;
`endif

  state_t          r_state;
  state_t          w_nextState;

  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [31:0]     r_adr;

  logic [17:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_countNext;

  logic            w_push;
  logic            w_pop;
  logic            w_lastX;
  logic            w_lastY;
  logic            w_sof;
  logic            w_eol;
  logic [17:0]     w_head;

`ifdef FB_READER_FAIRPLAY_EN
  logic [5:0]      r_burst;
  logic            w_burstWrap;
`endif

  assign wshb_dat_ms = 16'h0000;
  assign wshb_sel    = 2'b11;
  assign wshb_we     = 1'b0;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;
  assign wshb_adr    = r_adr;

  // Acks outside READ are ignored entirely.
  assign w_push      = (r_state == READ) && wshb_ack;
  assign w_pop       = (r_count != '0) && pix_ready;
  assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);

  assign w_lastX     = (r_x == XW'(HDISP - 1));
  assign w_lastY     = (r_y == YW'(VDISP - 1));
  assign w_sof       = (r_x == '0) && (r_y == '0);
  assign w_eol       = w_lastX;

`ifdef FB_READER_FAIRPLAY_EN
  assign w_burstWrap = w_push && (r_burst == 6'd63);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and bus strobes. A READ keeps going as long as the FIFO,
  // after this cycle's push and pop, still has room for one more entry
  // beyond the one that could be in flight.
  always_comb begin
    w_nextState = r_state;
    wshb_cyc    = 1'b0;
    wshb_stb    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count <= FILL_LIMIT) w_nextState = READ;
      end
      READ: begin
        wshb_cyc = 1'b1;
        wshb_stb = 1'b1;
        if (wshb_ack) begin
`ifdef FB_READER_FAIRPLAY_EN
          if (w_burstWrap)                    w_nextState = PAUSE;
          else if (w_countNext <= FILL_LIMIT) w_nextState = READ;
          else                                w_nextState = IDLE;
`else
          if (w_countNext <= FILL_LIMIT) w_nextState = READ;
          else                           w_nextState = IDLE;
`endif
        end
      end
`ifdef FB_READER_FAIRPLAY_EN
      // One bus-free cycle, then the same entry rule as IDLE.
      PAUSE: begin
        if (r_count <= FILL_LIMIT) w_nextState = READ;
        else                       w_nextState = IDLE;
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

  // Raster counters and the linear byte address that tracks them; the
  // address is stepped rather than multiplied out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_adr <= 32'h0;
    end else if (w_push) begin
      if (w_lastX) begin
        r_x <= '0;
        if (w_lastY) begin
          r_y   <= '0;
          r_adr <= 32'h0;
        end else begin
          r_y   <= r_y + YW'(1);
          r_adr <= r_adr + 32'd2;
        end
      end else begin
        r_x   <= r_x + XW'(1);
        r_adr <= r_adr + 32'd2;
      end
    end
  end

`ifdef FB_READER_FAIRPLAY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_burst <= 6'd0;
    end else if (w_push) begin
      r_burst <= r_burst + 6'd1;
    end
  end
`endif

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      r_count <= w_countNext;
    end
  end

  // FIFO storage, tagged with the frame/line markers of the fetched pixel.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wrPtr] <= {wshb_dat_sm, w_sof, w_eol};
    end
  end

  // Head outputs are forced to zero while empty so reset shows clean zeros
  // without having to clear the storage array.
  assign w_head    = r_mem[r_rdPtr];
  assign pix_valid = (r_count != '0);
  assign pix_data  = pix_valid ? w_head[17:2] : 16'h0000;
  assign pix_sof   = pix_valid & w_head[1];
  assign pix_eol   = pix_valid & w_head[0];

endmodule

// File: tb/tb_fb_reader.sv
// ---------------------------------------------------------------------------
// tb_fb_reader
//
// Self-checking bench for fb_reader. A Wishbone slave returns adr[16:1] with
// a programmable number of wait states. A scoreboard model tracks expected
// fetch/pop indices and checks every cycle; directed phases cover reset,
// streaming, mid-transfer reset, frame wrap, wait states and FIFO throttle.
// Frame height is reduced so a full frame fits in the cycle budget.
// ---------------------------------------------------------------------------
module tb_fb_reader;

  localparam int HDISP = 640;
  localparam int VDISP = 8;
  localparam int DEPTH = 64;
  localparam int FRAME = HDISP * VDISP;
  localparam int LOGN  = 6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wshb_adr;
  logic [15:0] wshb_dat_ms;
  logic [15:0] wshb_dat_sm;
  logic [1:0]  wshb_sel;
  logic        wshb_we;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic        wshb_stb;
  logic        wshb_cyc;
  logic        wshb_ack;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_valid;
  logic        pix_ready = 1'b0;

  int passCnt = 0;
  int totalCnt = 0;

  int fetchIdx = 0;
  int popIdx = 0;
  bit justReset = 1'b0;
  bit prevStall = 1'b0;
  bit pauseNext = 1'b0;
  bit steady = 1'b0;
  logic [31:0] prevAdr = 32'h0;
  logic [31:0] adrLog [LOGN];
  bit sofLog [LOGN];
  bit eolLog [LOGN];

  int waitStates = 0;
  int waitCnt = 0;

  fb_reader #(.HDISP(HDISP), .VDISP(VDISP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wshb_adr(wshb_adr), .wshb_dat_ms(wshb_dat_ms), .wshb_dat_sm(wshb_dat_sm),
    .wshb_sel(wshb_sel), .wshb_we(wshb_we), .wshb_cti(wshb_cti),
    .wshb_bte(wshb_bte), .wshb_stb(wshb_stb), .wshb_cyc(wshb_cyc),
    .wshb_ack(wshb_ack), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  // Slave: acks after waitStates idle cycles of an active strobe and
  // returns the pixel index of the address as data.
  assign wshb_ack    = wshb_stb && wshb_cyc && (waitCnt >= waitStates);
  assign wshb_dat_sm = wshb_adr[16:1];

  always @(posedge clk) begin
    if (!rst_n || !wshb_stb || wshb_ack) waitCnt <= 0;
    else                                 waitCnt <= waitCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit rdy, input int waits,
                               input bit steadyOn, input int cycles);
    pix_ready  = rdy;
    waitStates = waits;
    steady     = steadyOn;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitFetch(input int target, input int budget);
    int n = 0;
    while (fetchIdx < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("fetch_timeout", 32'(fetchIdx < target), 32'h0);
  endtask

  // Scoreboard: every cycle, compare the DUT against what the raster order
  // and FIFO occupancy say must be visible, then account for this cycle's
  // transfer and pop.
  always @(negedge clk) begin
    if (justReset) begin
      checkOutput("rst_stb_cyc", {30'h0, wshb_stb, wshb_cyc}, 32'h0);
      checkOutput("rst_adr", wshb_adr, 32'h0);
      checkOutput("rst_pix", {13'h0, pix_valid, pix_sof, pix_eol, pix_data}, 32'h0);
      justReset = 1'b0;
    end else if (rst_n) begin
      checkOutput("constants",
                  {8'h0, wshb_dat_ms, wshb_sel, wshb_we, wshb_cti, wshb_bte},
                  {8'h0, 16'h0, 2'b11, 1'b0, 3'b0, 2'b0});
      checkOutput("pix_valid", 32'(pix_valid), 32'((fetchIdx - popIdx) > 0));
      if (prevStall) begin
        checkOutput("stb_held", 32'(wshb_stb), 32'h1);
        checkOutput("adr_held", wshb_adr, prevAdr);
      end
      if (steady) begin
`ifdef FB_READER_FAIRPLAY_EN
        checkOutput("cyc_fairplay", 32'(wshb_cyc), 32'(!pauseNext));
`else
        checkOutput("cyc_steady", 32'(wshb_cyc), 32'h1);
`endif
      end
      pauseNext = 1'b0;
      if (wshb_stb && wshb_ack) begin
        checkOutput("fetch_adr", wshb_adr, 32'(2 * (fetchIdx % FRAME)));
        if (fetchIdx < LOGN) adrLog[fetchIdx] = wshb_adr;
        fetchIdx++;
        pauseNext = ((fetchIdx % 64) == 0);
      end
      if (pix_valid && pix_ready) begin
        checkOutput("pix_data", 32'(pix_data), 32'((popIdx % FRAME) & 16'hFFFF));
        checkOutput("pix_sof", 32'(pix_sof), 32'((popIdx % FRAME) == 0));
        checkOutput("pix_eol", 32'(pix_eol), 32'((popIdx % HDISP) == HDISP - 1));
        if (popIdx < LOGN) begin
          sofLog[popIdx] = pix_sof;
          eolLog[popIdx] = pix_eol;
        end
        popIdx++;
      end
      prevStall = wshb_stb && !wshb_ack;
      prevAdr   = wshb_adr;
    end
    if (!rst_n) begin
      fetchIdx  = 0;
      popIdx    = 0;
      justReset = 1'b1;
      prevStall = 1'b0;
      pauseNext = 1'b0;
    end
  end

  // Directed phases with hand-computed expectations that pin the model.
  initial begin
    int base;
    int delta;

    $display("[TB] reset and startup");
    applyStimulus(1'b1, 0, 1'b0, 3);
    checkOutput("init_stb", 32'(wshb_stb), 32'h0);
    checkOutput("init_valid", 32'(pix_valid), 32'h0);
    rst_n = 1'b1;
    steady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_stb", 32'(wshb_stb), 32'h1);
    checkOutput("first_adr", wshb_adr, 32'h0);

    $display("[TB] streaming to pixel 1000, then reset mid-transfer");
    waitFetch(1000, 1200);
    steady = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_stb", 32'(wshb_stb), 32'h0);
    checkOutput("midrst_valid", 32'(pix_valid), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("restart_stb", 32'(wshb_stb), 32'h1);
    checkOutput("restart_adr", wshb_adr, 32'h0);

    $display("[TB] full frame and wrap");
    steady = 1'b1;
    waitFetch(5200, 6000);
    checkOutput("adr_1", adrLog[1], 32'h2);
    checkOutput("adr_640", adrLog[640], 32'h500);
    checkOutput("adr_last", adrLog[5119], 32'h27FE);
    checkOutput("adr_wrap", adrLog[5120], 32'h0);
    checkOutput("sof_0", 32'(sofLog[0]), 32'h1);
    checkOutput("sof_1", 32'(sofLog[1]), 32'h0);
    checkOutput("eol_638", 32'(eolLog[638]), 32'h0);
    checkOutput("eol_639", 32'(eolLog[639]), 32'h1);
    checkOutput("eol_last", 32'(eolLog[5119]), 32'h1);
    checkOutput("sof_wrap", 32'(sofLog[5120]), 32'h1);

    $display("[TB] three wait states per transfer");
    base = fetchIdx;
    applyStimulus(1'b1, 3, 1'b0, 200);
    delta = fetchIdx - base;
    checkOutput("wait_rate", 32'(delta >= 48 && delta <= 51), 32'h1);

    $display("[TB] FIFO throttle");
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 2);
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 150);
    checkOutput("throttle_acks", 32'(fetchIdx), 32'd63);
    checkOutput("throttle_cyc", 32'(wshb_cyc), 32'h0);
    checkOutput("throttle_valid", 32'(pix_valid), 32'h1);
    applyStimulus(1'b1, 0, 1'b0, 1);
    applyStimulus(1'b0, 0, 1'b0, 30);
    checkOutput("one_more_ack", 32'(fetchIdx), 32'd64);
    checkOutput("one_more_cyc", 32'(wshb_cyc), 32'h0);
    applyStimulus(1'b1, 0, 1'b0, 120);
    checkOutput("drain_progress", 32'(popIdx > 100), 32'h1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
